// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and LSB requests onto an
// 8-bit RAM port, assembling or splitting 1/2/4-byte accesses.
module mem_ctrl #(
  parameter int unsigned ROB_SIZE_WIDTH = 4,
  parameter logic [1:0]  IO_ADDR_HI     = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      ifetch_valid,
  input  logic [31:0]               ifetch_addr,
  output logic                      ifetch_done,
  output logic [31:0]               ifetch_data,
  input  logic                      lsb_valid,
  input  logic                      lsb_we,
  input  logic [2:0]                lsb_op,
  input  logic [31:0]               lsb_addr,
  input  logic [31:0]               lsb_wdata,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  output logic [ROB_SIZE_WIDTH-1:0] lsb_done_rob_id,
  input  logic                      rob_clear,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [31:0]               addr_q, addr_d;
  logic [2:0]                op_q, op_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [31:0]               data_q, data_d;
  logic [ROB_SIZE_WIDTH-1:0] rob_id_q, rob_id_d;
  logic [31:0]               mem_a_q, mem_a_d;
  logic [7:0]                mem_dout_q, mem_dout_d;
  logic                      mem_wr_q, mem_wr_d;
  logic                      ifetch_done_q, ifetch_done_d;
  logic [31:0]               ifetch_data_q, ifetch_data_d;
  logic                      lsb_done_q, lsb_done_d;
  logic [31:0]               lsb_rdata_q, lsb_rdata_d;
  logic [ROB_SIZE_WIDTH-1:0] lsb_done_rob_id_q, lsb_done_rob_id_d;

  logic [2:0]  n_bytes;
  logic [2:0]  cnt_inc;
  logic [31:0] next_addr;
  logic [1:0]  cap_idx;
  logic [31:0] data_asm;
  logic        io_stall;

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    n_bytes   = op_q[1] ? 3'd4 : (op_q[0] ? 3'd2 : 3'd1);
    cnt_inc   = cnt_q + 3'd1;
    next_addr = addr_q + {29'd0, cnt_inc};
    // mem_din at this edge holds the byte whose address was driven two edges ago
    cap_idx   = cnt_q[1:0] - 2'd1;
    data_asm  = data_q;
    data_asm[{cap_idx, 3'b000} +: 8] = mem_din;
    io_stall  = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    addr_d            = addr_q;
    op_d              = op_q;
    wdata_d           = wdata_q;
    data_d            = data_q;
    rob_id_d          = rob_id_q;
    mem_a_d           = mem_a_q;
    mem_dout_d        = mem_dout_q;
    mem_wr_d          = mem_wr_q;
    ifetch_done_d     = 1'b0;
    ifetch_data_d     = ifetch_data_q;
    lsb_done_d        = 1'b0;
    lsb_rdata_d       = lsb_rdata_q;
    lsb_done_rob_id_d = lsb_done_rob_id_q;

    unique case (state_q)
      StIdle: begin
        if (!ifetch_done_q && !lsb_done_q && !rob_clear) begin
          if (lsb_valid) begin
            addr_d   = lsb_addr;
            op_d     = lsb_op;
            wdata_d  = lsb_wdata;
            rob_id_d = lsb_rob_id;
            cnt_d    = 3'd0;
            data_d   = '0;
            mem_a_d  = lsb_addr;
            if (lsb_we) begin
              state_d    = StStore;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = !((lsb_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
            end else begin
              state_d  = StLoad;
              mem_wr_d = 1'b0;
            end
          end else if (ifetch_valid) begin
            state_d  = StFetch;
            addr_d   = ifetch_addr;
            op_d     = 3'b010;
            cnt_d    = 3'd0;
            data_d   = '0;
            mem_a_d  = ifetch_addr;
            mem_wr_d = 1'b0;
          end
        end
      end
      StFetch, StLoad: begin
        if (rob_clear) begin
          state_d  = StIdle;
          mem_wr_d = 1'b0;
          cnt_d    = 3'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < n_bytes) mem_a_d = next_addr;
          if (cnt_q != 3'd0) data_d = data_asm;
          if (cnt_q == n_bytes) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            if (state_q == StFetch) begin
              ifetch_done_d = 1'b1;
              ifetch_data_d = data_asm;
            end else begin
              lsb_done_d        = 1'b1;
              lsb_rdata_d       = extend(op_q, data_asm);
              lsb_done_rob_id_d = rob_id_q;
            end
          end
        end
      end
      StStore: begin
        // A byte only counts as written if mem_wr was high at this edge
        if (mem_wr_q) begin
          if (cnt_inc == n_bytes) begin
            state_d           = StIdle;
            cnt_d             = 3'd0;
            mem_wr_d          = 1'b0;
            lsb_done_d        = 1'b1;
            lsb_rdata_d       = '0;
            lsb_done_rob_id_d = rob_id_q;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = next_addr;
            mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
            mem_wr_d   = !io_stall;
          end
        end else begin
          mem_wr_d = !io_stall;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      addr_q            <= '0;
      op_q              <= '0;
      wdata_q           <= '0;
      data_q            <= '0;
      rob_id_q          <= '0;
      mem_a_q           <= '0;
      mem_dout_q        <= '0;
      mem_wr_q          <= 1'b0;
      ifetch_done_q     <= 1'b0;
      ifetch_data_q     <= '0;
      lsb_done_q        <= 1'b0;
      lsb_rdata_q       <= '0;
      lsb_done_rob_id_q <= '0;
    end else if (rdy) begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      addr_q            <= addr_d;
      op_q              <= op_d;
      wdata_q           <= wdata_d;
      data_q            <= data_d;
      rob_id_q          <= rob_id_d;
      mem_a_q           <= mem_a_d;
      mem_dout_q        <= mem_dout_d;
      mem_wr_q          <= mem_wr_d;
      ifetch_done_q     <= ifetch_done_d;
      ifetch_data_q     <= ifetch_data_d;
      lsb_done_q        <= lsb_done_d;
      lsb_rdata_q       <= lsb_rdata_d;
      lsb_done_rob_id_q <= lsb_done_rob_id_d;
    end
  end

  assign ifetch_done     = ifetch_done_q;
  assign ifetch_data     = ifetch_data_q;
  assign lsb_done        = lsb_done_q;
  assign lsb_rdata       = lsb_rdata_q;
  assign lsb_done_rob_id = lsb_done_rob_id_q;
  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = mem_wr_q;

endmodule
